// File: rtl/l2_config_and_types.sv
// Shared L2 memory-interface constants and types used by the SRAM responder.
package l2_config_and_types;

   localparam int L2_ID_W = 5;
   localparam logic [4:0] AMO_LR = 5'b00010;

   localparam int L2_MAX_BURST_BEATS = 32;
   localparam int L2_BEAT_W = $clog2(L2_MAX_BURST_BEATS);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
   } l2_responder_state_t;

endpackage

// File: rtl/l2_sram_bank.sv
// Single-port synchronous-read SRAM with four byte lanes; contents start undefined.
module l2_sram_bank #(
   parameter int MEM_DEPTH_WORDS = 4096,
   parameter     INIT_FILE       = "",
   parameter int AW              = $clog2(MEM_DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [MEM_DEPTH_WORDS];

   // Read data is held between reads; the responder qualifies it with its own valid flag.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/l2_sram_responder.sv
// Memory-side responder for the L2 interface: pops one request at a time and serves
// single-word and burst reads/writes from an on-chip byte-enabled SRAM.
module l2_sram_responder
   import l2_config_and_types::*;
#(
   parameter int MEM_DEPTH_WORDS = 4096,
   parameter     INIT_FILE       = ""
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_request_valid,
   output logic               mem_request_pop,
   input  logic [29:0]        mem_addr,
   input  logic [3:0]         mem_be,
   input  logic               mem_rnw,
   input  logic               mem_is_amo,
   input  logic [4:0]         mem_amo_type_or_burst_size,
   input  logic [L2_ID_W-1:0] mem_id,
   input  logic               mem_abort,
   input  logic [31:0]        mem_wr_data,
   input  logic               mem_wr_data_valid,
   output logic               mem_wr_data_read,
   output logic [31:0]        mem_rd_data,
   output logic [L2_ID_W-1:0] mem_rd_id,
   output logic               mem_rd_data_valid,
   output logic               unsupported_amo
);

   localparam int AW = $clog2(MEM_DEPTH_WORDS);

   l2_responder_state_t  state_q, state_d;
   logic [29:0]          addr_q, addr_d;
   logic [3:0]           be_q, be_d;
   logic [L2_ID_W-1:0]   id_q, id_d;
   logic [L2_BEAT_W-1:0] last_q, last_d;
   logic [L2_BEAT_W-1:0] k_q, k_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [L2_ID_W-1:0]   rd_id_q, rd_id_d;
   logic                 unsupported_q, unsupported_d;
   logic                 active_q;

   logic                 request_pop;
   logic                 wr_data_read;
   logic                 sram_en;
   logic                 sram_we;
   logic [31:0]          sram_rdata;

   logic                 unused_abort;
   assign unused_abort = mem_abort;

   // AMOs always collapse to a single-word read; last_q holds beats-1 so k never needs a sixth bit.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      be_d          = be_q;
      id_d          = id_q;
      last_d        = last_q;
      k_d           = k_q;
      rd_valid_d    = 1'b0;
      rd_id_d       = rd_id_q;
      unsupported_d = unsupported_q;
      request_pop   = 1'b0;
      wr_data_read  = 1'b0;
      sram_en       = 1'b0;
      sram_we       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_request_valid && active_q) begin
               request_pop = 1'b1;
               addr_d      = mem_addr;
               be_d        = mem_be;
               id_d        = mem_id;
               k_d         = '0;
               last_d      = mem_is_amo ? '0 : mem_amo_type_or_burst_size;
               state_d     = (mem_rnw || mem_is_amo) ? READ : WRITE;
               if (mem_is_amo && (mem_amo_type_or_burst_size != AMO_LR)) unsupported_d = 1'b1;
            end
         end
         READ: begin
            sram_en    = 1'b1;
            rd_valid_d = 1'b1;
            rd_id_d    = id_q;
            addr_d     = addr_q + 30'd1;
            k_d        = k_q + 1'b1;
            if (k_q == last_q) state_d = IDLE;
         end
         WRITE: begin
            if (mem_wr_data_valid) begin
               wr_data_read = 1'b1;
               sram_en      = 1'b1;
               sram_we      = 1'b1;
               addr_d       = addr_q + 30'd1;
               k_d          = k_q + 1'b1;
               if (k_q == last_q) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // active_q keeps the pop low while reset is held without mixing rst into datapath logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         be_q          <= '0;
         id_q          <= '0;
         last_q        <= '0;
         k_q           <= '0;
         rd_valid_q    <= 1'b0;
         rd_id_q       <= '0;
         unsupported_q <= 1'b0;
         active_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         be_q          <= be_d;
         id_q          <= id_d;
         last_q        <= last_d;
         k_q           <= k_d;
         rd_valid_q    <= rd_valid_d;
         rd_id_q       <= rd_id_d;
         unsupported_q <= unsupported_d;
         active_q      <= 1'b1;
      end
   end

   l2_sram_bank #(
      .MEM_DEPTH_WORDS (MEM_DEPTH_WORDS),
      .INIT_FILE       (INIT_FILE),
      .AW              (AW)
   ) u_bank (
      .clk   (clk),
      .en    (sram_en),
      .we    (sram_we),
      .addr  (addr_q[AW-1:0]),
      .be    (be_q),
      .wdata (mem_wr_data),
      .rdata (sram_rdata)
   );

   assign mem_request_pop   = request_pop;
   assign mem_wr_data_read  = wr_data_read;
   assign mem_rd_data_valid = rd_valid_q;
   assign mem_rd_id         = rd_id_q;
   assign mem_rd_data       = rd_valid_q ? sram_rdata : 32'd0;
   assign unsupported_amo   = unsupported_q;

endmodule

// File: tb/tb_l2_sram_responder.sv
// Directed self-checking bench for l2_sram_responder using a 64-word memory so wrap is cheap to reach.
module tb_l2_sram_responder;
   import l2_config_and_types::*;

   localparam int DEPTH = 64;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               mem_request_valid = 1'b0;
   logic               mem_request_pop;
   logic [29:0]        mem_addr = '0;
   logic [3:0]         mem_be = '0;
   logic               mem_rnw = 1'b0;
   logic               mem_is_amo = 1'b0;
   logic [4:0]         mem_amo_type_or_burst_size = '0;
   logic [L2_ID_W-1:0] mem_id = '0;
   logic               mem_abort = 1'b0;
   logic [31:0]        mem_wr_data = '0;
   logic               mem_wr_data_valid = 1'b0;
   logic               mem_wr_data_read;
   logic [31:0]        mem_rd_data;
   logic [L2_ID_W-1:0] mem_rd_id;
   logic               mem_rd_data_valid;
   logic               unsupported_amo;

   l2_sram_responder #(
      .MEM_DEPTH_WORDS (DEPTH),
      .INIT_FILE       ("")
   ) dut (
      .clk                        (clk),
      .rst                        (rst),
      .mem_request_valid          (mem_request_valid),
      .mem_request_pop            (mem_request_pop),
      .mem_addr                   (mem_addr),
      .mem_be                     (mem_be),
      .mem_rnw                    (mem_rnw),
      .mem_is_amo                 (mem_is_amo),
      .mem_amo_type_or_burst_size (mem_amo_type_or_burst_size),
      .mem_id                     (mem_id),
      .mem_abort                  (mem_abort),
      .mem_wr_data                (mem_wr_data),
      .mem_wr_data_valid          (mem_wr_data_valid),
      .mem_wr_data_read           (mem_wr_data_read),
      .mem_rd_data                (mem_rd_data),
      .mem_rd_id                  (mem_rd_id),
      .mem_rd_data_valid          (mem_rd_data_valid),
      .unsupported_amo            (unsupported_amo)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   int test_count = 0;
   int fail_count = 0;
   int wr_pop_total = 0;

   logic [31:0]        rsp_data [$];
   logic [L2_ID_W-1:0] rsp_id [$];
   int                 rsp_cycle [$];
   logic [31:0]        wdata [32];

   // Responses and write-data pops are observed on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mem_rd_data_valid === 1'b1) begin
         rsp_data.push_back(mem_rd_data);
         rsp_id.push_back(mem_rd_id);
         rsp_cycle.push_back(cycle);
      end
      if (mem_wr_data_read === 1'b1) wr_pop_total++;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] data_at(input int i);
      return (i < rsp_data.size()) ? rsp_data[i] : 32'bx;
   endfunction

   function automatic logic [31:0] id_at(input int i);
      return (i < rsp_id.size()) ? 32'(rsp_id[i]) : 32'bx;
   endfunction

   function automatic logic [31:0] cyc_at(input int i);
      return (i < rsp_cycle.size()) ? 32'(rsp_cycle[i]) : 32'bx;
   endfunction

   task automatic clear_rsp();
      rsp_data.delete();
      rsp_id.delete();
      rsp_cycle.delete();
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Starts and ends one time unit after a rising edge; returns the cycle in which the pop was seen.
   task automatic apply_stimulus(input logic [29:0] a, input logic [3:0] b, input logic rnw_i,
                                 input logic amo_i, input logic [4:0] bs,
                                 input logic [L2_ID_W-1:0] id_i, output int pop_cyc);
      int guard;
      guard = 0;
      pop_cyc = -1;
      mem_addr = a;
      mem_be = b;
      mem_rnw = rnw_i;
      mem_is_amo = amo_i;
      mem_amo_type_or_burst_size = bs;
      mem_id = id_i;
      mem_request_valid = 1'b1;
      while (pop_cyc < 0 && guard < 50) begin
         @(negedge clk);
         if (mem_request_pop === 1'b1) pop_cyc = cycle;
         @(posedge clk);
         #1;
         guard++;
      end
      mem_request_valid = 1'b0;
      check_output("pop_seen", 32'(pop_cyc >= 0), 32'd1);
   endtask

   task automatic write_burst(input logic [29:0] a, input logic [3:0] b, input int beats, input bit toggle);
      int p;
      int idx;
      int guard;
      int start_pops;
      idx = 0;
      guard = 0;
      start_pops = wr_pop_total;
      apply_stimulus(a, b, 1'b0, 1'b0, 5'(beats - 1), '0, p);
      while (idx < beats && guard < 100) begin
         mem_wr_data = wdata[idx];
         mem_wr_data_valid = toggle ? (guard % 2 == 0) : 1'b1;
         @(negedge clk);
         if (mem_wr_data_read === 1'b1) idx++;
         @(posedge clk);
         #1;
         guard++;
      end
      mem_wr_data_valid = 1'b0;
      drain(2);
      check_output($sformatf("wr_pops_%0h", a), 32'(wr_pop_total - start_pops), 32'(beats));
   endtask

   task automatic read_req(input logic [29:0] a, input logic [L2_ID_W-1:0] id_i, input logic [4:0] bs,
                           input logic amo_i, output int p);
      clear_rsp();
      apply_stimulus(a, 4'hF, 1'b1, amo_i, bs, id_i, p);
      drain(int'(bs) + 4);
   endtask

   task automatic check_rsp(input string tag, input int i, input logic [31:0] ed,
                            input logic [L2_ID_W-1:0] eid, input int ecyc);
      check_output($sformatf("%s_data%0d", tag, i), data_at(i), ed);
      check_output($sformatf("%s_id%0d", tag, i), id_at(i), 32'(eid));
      check_output($sformatf("%s_cycle%0d", tag, i), cyc_at(i), 32'(ecyc));
   endtask

   initial begin
      int p;
      int p2;

      // Reset with a request pending: nothing may be popped while reset is held.
      #1 rst = 1'b0;
      mem_request_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_pop", 32'(mem_request_pop), 32'd0);
      check_output("reset_wr_read", 32'(mem_wr_data_read), 32'd0);
      check_output("reset_rd_valid", 32'(mem_rd_data_valid), 32'd0);
      check_output("reset_rd_data", mem_rd_data, 32'd0);
      check_output("reset_rd_id", 32'(mem_rd_id), 32'd0);
      check_output("reset_unsupported", 32'(unsupported_amo), 32'd0);
      mem_request_valid = 1'b0;
      rst = 1'b1;
      drain(2);

      // Full-word write then single read with id 5.
      wdata[0] = 32'hDEADBEEF;
      write_burst(30'h10, 4'hF, 1, 1'b0);
      read_req(30'h10, 5'd5, 5'd0, 1'b0, p);
      check_output("single_count", 32'(rsp_data.size()), 32'd1);
      check_rsp("single", 0, 32'hDEADBEEF, 5'd5, p + 2);

      // Partial write over an existing word.
      wdata[0] = 32'h11223344;
      write_burst(30'h30, 4'hF, 1, 1'b0);
      wdata[0] = 32'h0000AB00;
      write_burst(30'h30, 4'b0010, 1, 1'b0);
      read_req(30'h30, 5'd3, 5'd0, 1'b0, p);
      check_output("partial_count", 32'(rsp_data.size()), 32'd1);
      check_output("partial_data", data_at(0), 32'h1122AB44);

      // Eight-beat burst write with gapped write data, then an eight-beat read.
      for (int i = 0; i < 8; i++) wdata[i] = 32'hC0DE0000 + 32'(i) * 32'h00001111;
      write_burst(30'h20, 4'hF, 8, 1'b1);
      read_req(30'h20, 5'd2, 5'd7, 1'b0, p);
      check_output("burst_count", 32'(rsp_data.size()), 32'd8);
      for (int i = 0; i < 8; i++) check_rsp("burst", i, 32'hC0DE0000 + 32'(i) * 32'h00001111, 5'd2, p + 2 + i);

      // Burst crossing the top of memory wraps to word 0, for both writes and reads.
      for (int i = 0; i < 4; i++) wdata[i] = 32'h5A5A0000 + 32'(i);
      write_burst(30'(DEPTH - 2), 4'hF, 4, 1'b0);
      read_req(30'(DEPTH - 2), 5'd4, 5'd3, 1'b0, p);
      check_output("wrap_count", 32'(rsp_data.size()), 32'd4);
      for (int i = 0; i < 4; i++) check_output($sformatf("wrap_data%0d", i), data_at(i), 32'h5A5A0000 + 32'(i));
      read_req(30'h0, 5'd4, 5'd0, 1'b0, p);
      check_output("wrap_word0", data_at(0), 32'h5A5A0002);
      read_req(30'(2 * DEPTH - 1), 5'd4, 5'd0, 1'b0, p);
      check_output("upper_addr_ignored", data_at(0), 32'h5A5A0001);

      // Reset in the middle of an eight-beat read burst abandons the rest of it.
      clear_rsp();
      apply_stimulus(30'h20, 4'hF, 1'b1, 1'b0, 5'd7, 5'd6, p);
      drain(2);
      rst = 1'b0;
      @(negedge clk);
      check_output("midreset_rsp_before", 32'(rsp_data.size()), 32'd1);
      check_output("midreset_rd_valid", 32'(mem_rd_data_valid), 32'd0);
      check_output("midreset_rd_data", mem_rd_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_rsp();
      drain(12);
      check_output("midreset_abandoned", 32'(rsp_data.size()), 32'd0);
      read_req(30'h20, 5'd6, 5'd0, 1'b0, p);
      check_output("after_reset_count", 32'(rsp_data.size()), 32'd1);
      check_output("after_reset_data", data_at(0), 32'hC0DE0000);

      // Back-to-back queued reads: in-order responses with a bubble cycle between them.
      clear_rsp();
      apply_stimulus(30'h10, 4'hF, 1'b1, 1'b0, 5'd0, 5'd1, p);
      apply_stimulus(30'h30, 4'hF, 1'b1, 1'b0, 5'd0, 5'd2, p2);
      drain(4);
      check_output("b2b_pop_gap", 32'(p2 - p), 32'd2);
      check_output("b2b_count", 32'(rsp_data.size()), 32'd2);
      check_rsp("b2b", 0, 32'hDEADBEEF, 5'd1, p + 2);
      check_rsp("b2b", 1, 32'h1122AB44, 5'd2, p + 4);

      // LR is a single-word read and is supported.
      read_req(30'h10, 5'd9, AMO_LR, 1'b1, p);
      check_output("lr_count", 32'(rsp_data.size()), 32'd1);
      check_output("lr_data", data_at(0), 32'hDEADBEEF);
      check_output("lr_unsupported", 32'(unsupported_amo), 32'd0);

      // Any other AMO is a single-word read that raises the sticky flag.
      clear_rsp();
      apply_stimulus(30'h30, 4'hF, 1'b0, 1'b1, 5'b00001, 5'd10, p);
      check_output("amo_unsupported_set", 32'(unsupported_amo), 32'd1);
      drain(6);
      check_output("amo_count", 32'(rsp_data.size()), 32'd1);
      check_rsp("amo", 0, 32'h1122AB44, 5'd10, p + 2);
      check_output("amo_unsupported_sticky", 32'(unsupported_amo), 32'd1);
      rst = 1'b0;
      #2;
      check_output("amo_unsupported_reset", 32'(unsupported_amo), 32'd0);
      rst = 1'b1;
      drain(2);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
